pwm_nch: RTL and testbench
==========================

PWM_NCH -- requirements
Module: pwm_nch

Interface
REQ-001 Parameter CH_NUM, default 8, number of PWM channels (1..32).
REQ-002 Parameter CNT_W, default 32, width of period/duty/counter values (2..32).
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RST_n  in  1  asynchronous active-low reset; assertion immediate, release synchronous to CLK.
REQ-005 EN  in  1  1 = counter runs, 0 = counter held at 0 and outputs idle.
REQ-006 MODE  in  1  0 = edge-aligned, 1 = center-aligned; sampled only at shadow load.
REQ-007 PERIOD_Set  in  CNT_W  period value P (staging).
REQ-008 DUTY_Set  in  CH_NUM*CNT_W  channel i duty D[i] in bits [i*CNT_W +: CNT_W] (staging).
REQ-009 POL  in  CH_NUM  per-channel polarity; 1 inverts active level; applied live, not shadowed.
REQ-010 LOAD_REQ  in  1  request to copy staging values into active registers at next period boundary.
REQ-011 LOAD_ACK  out  1  one-cycle pulse in the cycle active registers take new values.
REQ-012 PERIOD_END  out  1  one-cycle pulse in the first cycle of each new period.
REQ-013 CNT  out  CNT_W  current counter value.
REQ-014 PWM_OUT  out  CH_NUM  registered PWM outputs.

Function
REQ-015 Active registers act_P, act_D[i], act_MODE SHALL be the only values used for counting/compare; staging inputs SHALL never affect a running period.
REQ-016 While EN=0: CNT=0, dir=up, active registers copy staging every cycle, load_pending cleared, LOAD_ACK=0, PERIOD_END=0.
REQ-017 Edge mode: CNT sequence 0,1,..,act_P, then 0; period act_P+1 cycles; act_P=0 -> CNT stays 0, every cycle a wrap.
REQ-018 Center mode: CNT sequence 0,1,..,act_P,act_P-1,..,1, then 0; period 2*act_P cycles; act_P=0 -> CNT stays 0, every cycle a wrap.
REQ-019 Wrap cycle = cycle whose next CNT is 0 with EN=1; next cycle is first cycle of a new period.
REQ-020 LOAD_REQ=1 sets load_pending; LOAD_REQ while pending SHALL have no further effect.
REQ-021 At a wrap cycle with load_pending=1 or LOAD_REQ=1: next cycle active registers = staging values of the wrap cycle, load_pending=0, LOAD_ACK=1, dir=up.
REQ-022 PERIOD_END SHALL be 1 exactly in each cycle following a wrap cycle (CNT=0 at that cycle).
REQ-023 Raw compare raw[i] = (CNT < act_D[i]); D=0 -> always inactive; D>act_P (edge) or D>act_P (center) -> always active.
REQ-024 PWM_OUT[i] SHALL register, one cycle after the CNT value it reflects, raw[i] XOR POL[i] when EN=1, and POL[i] when EN=0.
REQ-025 EN 1->0 mid-period: next cycle CNT=0, PWM_OUT=POL, pending load discarded (staging already tracked per REQ-016).
REQ-026 EN 0->1: first enabled cycle CNT=0 with active values from the last disabled cycle; no PERIOD_END for that first cycle.
REQ-027 Counter arithmetic SHALL be CNT_W bits unsigned; act_P=2^CNT_W-1 SHALL wrap to 0 without overflow error.

Reset
REQ-028 On RST_n=0: CNT=0, dir=up, all active registers=0, load_pending=0, LOAD_ACK=0, PERIOD_END=0, PWM_OUT=0 (all bits), regardless of POL.
REQ-029 Reset asserted mid-period SHALL abort the period; after release behaviour follows REQ-016/REQ-026.

Verification
REQ-030 Edge, CH_NUM=2, P=9, D={3,10}, POL=0, EN=1 -> ch0 high 3 of 10 cycles, ch1 constantly high, PERIOD_END every 10 cycles.
REQ-031 Center, P=4, D=2 -> CNT 0,1,2,3,4,3,2,1 repeating; PWM_OUT high on cycles following CNT 0,1,1 (3 of 8), symmetric about CNT=4.
REQ-032 Running P=9, change PERIOD_Set=4/DUTY_Set=2 and pulse LOAD_REQ at CNT=5 -> current period completes at 10 cycles, LOAD_ACK with CNT=0, next period 5 cycles, duty 2.
REQ-033 LOAD_REQ exactly in wrap cycle -> load at that boundary, LOAD_ACK next cycle; second LOAD_REQ while pending -> single LOAD_ACK.
REQ-034 POL=1, D=0 -> output constantly 1; EN dropped at CNT=6 -> next cycle CNT=0, PWM_OUT=1, no PERIOD_END.
REQ-035 RST_n low at CNT=7 -> CNT=0, PWM_OUT=0, LOAD_ACK=0 immediately, before next CLK edge.

Source files
------------

// File: rtl/pwm_nch.sv
// Multi-channel PWM with shadowed period/duty registers.
// Edge- or center-aligned counting, loads only at period boundaries.
module pwm_nch #(
   parameter int CH_NUM = 8,
   parameter int CNT_W  = 32
) (
   input  logic                    CLK,
   input  logic                    RST_n,
   input  logic                    EN,
   input  logic                    MODE,
   input  logic [CNT_W-1:0]        PERIOD_Set,
   input  logic [CH_NUM*CNT_W-1:0] DUTY_Set,
   input  logic [CH_NUM-1:0]       POL,
   input  logic                    LOAD_REQ,
   output logic                    LOAD_ACK,
   output logic                    PERIOD_END,
   output logic [CNT_W-1:0]        CNT,
   output logic [CH_NUM-1:0]       PWM_OUT
);

   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } dir_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   dir_t             dir;
   dir_t             dir_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wrap;
   logic             load_now;
   logic             pending;
   logic             act_mode;
   logic [CNT_W-1:0] act_p;
   logic [CNT_W-1:0] act_d [CH_NUM];
   logic [CH_NUM-1:0] raw;

   // Next counter value, direction and period-boundary detection
   always_comb begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
      wrap    = 1'b0;
      if (act_p == '0) begin
         cnt_nxt = '0;
      end else if (!act_mode) begin
         cnt_nxt = (CNT >= act_p) ? '0 : CNT + ONE;
      end else begin
         unique case (dir)
            DIR_UP: begin
               if (CNT >= act_p) begin
                  cnt_nxt = CNT - ONE;
                  dir_nxt = DIR_DOWN;
               end else begin
                  cnt_nxt = CNT + ONE;
                  dir_nxt = DIR_UP;
               end
            end
            DIR_DOWN: begin
               cnt_nxt = CNT - ONE;
               dir_nxt = DIR_DOWN;
            end
            default: begin
               cnt_nxt = '0;
               dir_nxt = DIR_UP;
            end
         endcase
      end
      wrap = (cnt_nxt == '0);
      if (wrap) dir_nxt = DIR_UP;
   end

   // Shadow load happens only on a wrap with a request outstanding
   always_comb begin
      load_now = wrap && (pending || LOAD_REQ);
   end

   // Per-channel compare against the active duty values
   always_comb begin
      raw = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         raw[i] = (CNT < act_d[i]);
      end
   end

   // Counter, direction and period-end pulse
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         CNT        <= '0;
         dir        <= DIR_UP;
         PERIOD_END <= 1'b0;
      end else if (!EN) begin
         CNT        <= '0;
         dir        <= DIR_UP;
         PERIOD_END <= 1'b0;
      end else begin
         CNT        <= cnt_nxt;
         dir        <= dir_nxt;
         PERIOD_END <= wrap;
      end
   end

   // Active registers: track staging while idle, else load at boundary
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         act_p    <= '0;
         act_mode <= 1'b0;
         for (int i = 0; i < CH_NUM; i++) act_d[i] <= '0;
         pending  <= 1'b0;
         LOAD_ACK <= 1'b0;
      end else if (!EN || load_now) begin
         act_p    <= PERIOD_Set;
         act_mode <= MODE;
         for (int i = 0; i < CH_NUM; i++) begin
            act_d[i] <= DUTY_Set[i*CNT_W +: CNT_W];
         end
         pending  <= 1'b0;
         LOAD_ACK <= EN;
      end else begin
         pending  <= pending | LOAD_REQ;
         LOAD_ACK <= 1'b0;
      end
   end

   // Registered outputs; polarity applies live, idle level is POL
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         PWM_OUT <= '0;
      end else if (!EN) begin
         PWM_OUT <= POL;
      end else begin
         PWM_OUT <= raw ^ POL;
      end
   end

endmodule

// File: tb/tb_pwm_nch.sv
// Bench for pwm_nch: phase-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_pwm_nch;

   localparam int CH = 2;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          mode;
   logic [W-1:0]  period_set;
   logic [CH*W-1:0] duty_set;
   logic [CH-1:0] pol;
   logic          load_req;
   logic          load_ack;
   logic          period_end;
   logic [W-1:0]  cnt;
   logic [CH-1:0] pwm_out;

   int total = 0;
   int bad   = 0;

   pwm_nch #(.CH_NUM(CH), .CNT_W(W)) dut (
      .CLK(clk),
      .RST_n(rst_n),
      .EN(en),
      .MODE(mode),
      .PERIOD_Set(period_set),
      .DUTY_Set(duty_set),
      .POL(pol),
      .LOAD_REQ(load_req),
      .LOAD_ACK(load_ack),
      .PERIOD_END(period_end),
      .CNT(cnt),
      .PWM_OUT(pwm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Reference model: active values plus phase index within the period
   int      m_p = 0;
   int      m_d [CH] = '{0, 0};
   bit      m_mode = 0;
   longint  m_k = 0;
   bit      m_pend = 0;
   bit      m_ack = 0;
   bit      m_pe = 0;
   logic [CH-1:0] m_pwm = '0;

   function automatic longint plen();
      if (!m_mode) return longint'(m_p) + 1;
      return (m_p == 0) ? 1 : 2 * longint'(m_p);
   endfunction

   function automatic longint ecnt();
      if (!m_mode) return m_k;
      if (m_p == 0) return 0;
      return (m_k <= m_p) ? m_k : 2 * longint'(m_p) - m_k;
   endfunction

   task automatic m_load();
      m_p    = int'(period_set);
      m_mode = mode;
      for (int i = 0; i < CH; i++) m_d[i] = int'(duty_set[i*W +: W]);
   endtask

   task automatic m_reset();
      m_p = 0;
      m_mode = 0;
      for (int i = 0; i < CH; i++) m_d[i] = 0;
      m_k = 0; m_pend = 0; m_ack = 0; m_pe = 0; m_pwm = '0;
   endtask

   task automatic m_step();
      logic [CH-1:0] np;
      longint c;
      c = ecnt();
      for (int i = 0; i < CH; i++) np[i] = (c < m_d[i]) ^ pol[i];
      if (!en) begin
         m_load();
         m_k = 0; m_pend = 0; m_ack = 0; m_pe = 0; m_pwm = pol;
      end else begin
         m_pwm = np;
         if (m_k + 1 >= plen()) begin
            m_k  = 0;
            m_pe = 1;
            if (m_pend || load_req) begin
               m_load();
               m_ack  = 1;
               m_pend = 0;
            end else begin
               m_ack = 0;
            end
         end else begin
            m_k++;
            m_pe  = 0;
            m_ack = 0;
            if (load_req) m_pend = 1;
         end
      end
   endtask

   // Advance the model on each edge and compare shortly after
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else m_step();
      #1;
      chk("cnt", cnt, ecnt());
      chk("pwm_out", pwm_out, m_pwm);
      chk("load_ack", load_ack, m_ack);
      chk("period_end", period_end, m_pe);
   end

   task automatic wait_cnt(input int v);
      int n;
      n = 0;
      while (cnt != v && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (cnt != v) timeout("wait_cnt");
   endtask

   task automatic load(input int p, input int d0, input int d1, input bit md);
      int n;
      period_set = W'(p);
      duty_set   = {W'(d1), W'(d0)};
      mode       = md;
      load_req   = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      n = 0;
      while (!load_ack && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!load_ack) timeout("load_ack wait");
   endtask

   int h0, h1, npe, n, acks;
   int seq [8];
   int exp_seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 1'b0;
      period_set = 8'd9; duty_set = {8'd10, 8'd3};
      pol = 2'b11; load_req = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("reset cnt", cnt, 0);
      chk("reset pwm ignores pol", pwm_out, 0);
      chk("reset ack", load_ack, 0);
      pol = 2'b00;
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      en = 1'b1;

      // edge P=9, D={3,10}
      n = 0;
      while (!period_end && n < 50) begin @(negedge clk); n++; end
      if (!period_end) timeout("first period_end");
      h0 = 0; h1 = 0; npe = 0;
      for (int j = 0; j < 10; j++) begin
         h0 += pwm_out[0]; h1 += pwm_out[1]; npe += period_end;
         @(negedge clk);
      end
      chk("edge ch0 high", h0, 3);
      chk("edge ch1 high", h1, 10);
      chk("edge pe per 10", npe, 1);
      chk("edge pe again", period_end, 1);

      // mid-period load request at CNT=5
      wait_cnt(5);
      period_set = 8'd4; duty_set = {8'd2, 8'd2};
      load_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         load_req = 1'b0;
         n++;
      end while (!load_ack && n < 50);
      chk("req to ack cycles", n, 5);
      chk("ack cnt", cnt, 0);
      chk("ack pe", period_end, 1);
      n = 0; h0 = 0;
      do begin
         h0 += pwm_out[0];
         @(negedge clk);
         n++;
      end while (!period_end && n < 50);
      chk("new period len", n, 5);
      chk("new duty high", h0, 2);

      // request in the wrap cycle, then a doubled request
      period_set = 8'd6; duty_set = {8'd1, 8'd1};
      wait_cnt(4);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      chk("wrap req ack", load_ack, 1);
      chk("wrap req cnt", cnt, 0);
      period_set = 8'd3;
      wait_cnt(2);
      load_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      load_req = 1'b0;
      acks = 0;
      for (int j = 0; j < 20; j++) begin
         acks += load_ack;
         @(negedge clk);
      end
      chk("single ack", acks, 1);

      // center P=4, D=2
      load(4, 2, 2, 1'b1);
      h0 = 0;
      for (int j = 0; j < 8; j++) begin
         seq[j] = int'(cnt);
         @(negedge clk);
         h0 += pwm_out[0];
      end
      for (int j = 0; j < 8; j++) chk("center seq", seq[j], exp_seq[j]);
      chk("center high", h0, 3);
      chk("center pe", period_end, 1);

      // full-range period wraps cleanly
      load(255, 128, 0, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!period_end && n < 600);
      chk("max period len", n, 256);

      // inverted zero duty, then EN drop at CNT=6
      load(9, 0, 5, 1'b0);
      pol = 2'b01;
      @(negedge clk); @(negedge clk);
      h0 = 0;
      for (int j = 0; j < 10; j++) begin
         h0 += pwm_out[0];
         @(negedge clk);
      end
      chk("pol d0 high", h0, 10);
      wait_cnt(6);
      en = 1'b0;
      @(negedge clk);
      chk("en drop cnt", cnt, 0);
      chk("en drop pwm", pwm_out, 1);
      chk("en drop pe", period_end, 0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      chk("en rise cnt", cnt, 1);
      chk("en rise pe", period_end, 0);

      // async reset at CNT=7
      wait_cnt(7);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst cnt", cnt, 0);
      chk("async rst pwm", pwm_out, 0);
      chk("async rst ack", load_ack, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
